pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_sat_counter.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared state encoding and parameter limits for the pipeline
//                hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Controller states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_RMW_HOLD = 2'd2
    } state_t;

    // Width of the shared stall/freeze down-counter
    localparam int c_CNT_BITS = 3;

    // Legal ranges for the timing parameters
    localparam int c_LOAD_LAT_MIN   = 1;
    localparam int c_LOAD_LAT_MAX   = 8;
    localparam int c_RMW_CYCLES_MIN = 2;
    localparam int c_RMW_CYCLES_MAX = 8;

endpackage
`default_nettype wire

// File: rtl/hazard_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sat_counter
//  Description : Enable-gated up-counter that sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, holding once every bit is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Load-use stall, sub-word store freeze and branch flush
//                control for a 5-stage pipeline, with a stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int LOAD_LAT   = 1,
    parameter int RMW_CYCLES = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic [REG_W-1:0] if_id_rs1,
    input  logic [REG_W-1:0] if_id_rs2,
    input  logic             if_id_use_rs1,
    input  logic             if_id_use_rs2,
    input  logic             mem_write_bh,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cycles
);

    // Reject out-of-range timing parameters at elaboration
    if ((LOAD_LAT < c_LOAD_LAT_MIN) || (LOAD_LAT > c_LOAD_LAT_MAX)) begin : g_bad_load_lat
        $error("pipeline_hazard_ctrl: LOAD_LAT out of range");
    end
    if ((RMW_CYCLES < c_RMW_CYCLES_MIN) || (RMW_CYCLES > c_RMW_CYCLES_MAX)) begin : g_bad_rmw
        $error("pipeline_hazard_ctrl: RMW_CYCLES out of range");
    end

    localparam logic [c_CNT_BITS-1:0] c_RMW_LOAD = c_CNT_BITS'(RMW_CYCLES - 2);
    localparam logic [c_CNT_BITS-1:0] c_LU_LOAD  = c_CNT_BITS'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

    state_t                r_state;
    state_t                w_state_nx;
    logic [c_CNT_BITS-1:0] r_cnt;
    logic [c_CNT_BITS-1:0] w_cnt_nx;
    logic                  w_hazard;
    logic                  w_stall_evt;

    // Register 0 is hardwired, so a load targeting it never creates a hazard
    assign w_hazard = id_ex_memread && (id_ex_rd != '0) &&
                      ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                       (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));

    // State and down-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Next-state and zero-latency pipeline control outputs
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        bubble      = 1'b0;
        if_id_flush = 1'b0;

        if ((r_state != ST_RMW_HOLD) && mem_write_bh) begin
            // Sub-word store read-modify-write: freeze the whole pipe
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_en  = 1'b0;
            w_cnt_nx   = c_RMW_LOAD;
            w_state_nx = ST_RMW_HOLD;
        end else if (r_state == ST_LU_STALL) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            bubble   = 1'b1;
            if (r_cnt == '0) begin
                w_state_nx = ST_RUN;
            end else begin
                w_cnt_nx = r_cnt - c_CNT_BITS'(1);
            end
        end else if ((r_state == ST_RMW_HOLD) && (r_cnt != '0)) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            w_cnt_nx  = r_cnt - c_CNT_BITS'(1);
        end else begin
            // RUN, or the release cycle of a freeze
            w_state_nx = ST_RUN;
            if (branch_taken) begin
                // The flushed instruction makes any load-use hazard moot
                if_id_flush = 1'b1;
                bubble      = 1'b1;
            end else if (w_hazard) begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                bubble   = 1'b1;
                if (LOAD_LAT > 1) begin
                    w_cnt_nx   = c_LU_LOAD;
                    w_state_nx = ST_LU_STALL;
                end
            end
        end

        // Hold the pipe and keep a NOP in ID/EX while in reset
        if (!rst_n) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
            bubble      = 1'b1;
            if_id_flush = 1'b0;
        end
    end

    assign w_stall_evt = !pc_en || !if_id_en;

    hazard_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_stall_evt),
        .o_count (stall_cycles)
    );

endmodule
`default_nettype wire
